// File: rtl/mmu_pkg.sv
// Shared MMU definitions: controller state encoding, PTE bit positions
// and the accessed/dirty mark request bundle.
package mmu_pkg;

  localparam int PTE_V = 0;
  localparam int PTE_A = 6;
  localparam int PTE_D = 7;

  typedef enum logic [2:0] {
    CTRL_IDLE     = 3'd0,
    CTRL_WALK_RD  = 3'd1,
    CTRL_MARK_RD  = 3'd2,
    CTRL_MARK_MOD = 3'd3,
    CTRL_MARK_WR  = 3'd4,
    CTRL_DONE     = 3'd5
  } ctrl_state_e;

  typedef struct packed {
    logic        accessed;
    logic        dirty;
    logic [63:0] addr;
  } pte_mark_req_t;

  // Setting D implies A, so dirty feeds both bits.
  function automatic logic [63:0] pte_set_ad(input logic [63:0] pte,
                                             input logic        accessed,
                                             input logic        dirty);
    logic [63:0] res;
    res        = pte;
    res[PTE_A] = pte[PTE_A] | accessed | dirty;
    res[PTE_D] = pte[PTE_D] | dirty;
    return res;
  endfunction

endpackage

// File: rtl/ptw_mem_timeout.sv
// Saturating per-transaction watchdog; counts only while enabled and
// restarts from zero whenever cleared or idle.
module ptw_mem_timeout #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            CW    = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] count;

  // Dropping to zero while disabled keeps a saturated count from a previous
  // transaction from expiring the next one on its first cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || !enable) begin
      count <= '0;
    end else if (count != LIMIT) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/ptw_mem_ctrl.sv
// Memory port controller for the page-table walker: serialises PTE loads and
// atomic accessed/dirty read-modify-write marks onto one 64-bit port.
module ptw_mem_ctrl
  import mmu_pkg::*;
#(
  parameter int PA_WIDTH = 32,
  parameter int TIMEOUT  = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                walk_req_valid,
  input  logic [PA_WIDTH-1:0] walk_req_addr,
  output logic                walk_rsp_valid,
  output logic [63:0]         walk_rsp_data,
  input  logic                mark_valid,
  input  logic                mark_accessed,
  input  logic                mark_dirty,
  input  logic [63:0]         mark_addr,
  output logic                mark_rsp_valid,
  output logic                mark_fault,
  output logic                mem_req_valid,
  output logic [PA_WIDTH-1:0] mem_req_addr,
  output logic                mem_req_store,
  output logic [63:0]         mem_req_data,
  input  logic                mem_rsp_valid,
  input  logic [63:0]         mem_rsp_data,
  output logic                timeout_err,
  output logic                busy,
  output logic [2:0]          ctrl_state
);

  localparam logic [2:0] IDLE     = CTRL_IDLE;
  localparam logic [2:0] WALK_RD  = CTRL_WALK_RD;
  localparam logic [2:0] MARK_RD  = CTRL_MARK_RD;
  localparam logic [2:0] MARK_MOD = CTRL_MARK_MOD;
  localparam logic [2:0] MARK_WR  = CTRL_MARK_WR;
  localparam logic [2:0] DONE     = CTRL_DONE;

  logic [2:0]          state_q, state_d;
  logic                walk_pend_q, walk_pend_d;
  logic [PA_WIDTH-1:0] walk_addr_q, walk_addr_d;
  logic                mark_pend_q, mark_pend_d;
  pte_mark_req_t       mark_req_q, mark_req_d;
  logic                cur_acc_q, cur_acc_d;
  logic                cur_dirty_q, cur_dirty_d;
  logic [63:0]         pte_new_q, pte_new_d;
  logic                store_needed_q, store_needed_d;

  logic                req_valid_d, req_store_d;
  logic [PA_WIDTH-1:0] req_addr_d;
  logic [63:0]         req_data_d;
  logic                walk_rsp_valid_d, mark_rsp_valid_d, mark_fault_d;
  logic [63:0]         walk_rsp_data_d;
  logic                timeout_d, busy_d;

  logic                waiting, expired;
  logic [63:0]         rsp_marked;

  function automatic logic [PA_WIDTH-1:0] align8(input logic [PA_WIDTH-1:0] a);
    return {a[PA_WIDTH-1:3], 3'b000};
  endfunction

  assign waiting    = (state_q == WALK_RD) || (state_q == MARK_RD) || (state_q == MARK_WR);
  assign rsp_marked = pte_set_ad(mem_rsp_data, cur_acc_q, cur_dirty_q);

  ptw_mem_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (mem_req_valid),
    .enable  (waiting),
    .expired (expired)
  );

  // The modified PTE and the store decision are formed as the read data
  // arrives, so a no-store mark answers one cycle after the read response.
  always_comb begin
    state_d          = state_q;
    walk_pend_d      = walk_pend_q;
    walk_addr_d      = walk_addr_q;
    mark_pend_d      = mark_pend_q;
    mark_req_d       = mark_req_q;
    cur_acc_d        = cur_acc_q;
    cur_dirty_d      = cur_dirty_q;
    pte_new_d        = pte_new_q;
    store_needed_d   = store_needed_q;
    req_valid_d      = 1'b0;
    req_addr_d       = mem_req_addr;
    req_store_d      = mem_req_store;
    req_data_d       = mem_req_data;
    walk_rsp_valid_d = 1'b0;
    walk_rsp_data_d  = walk_rsp_data;
    mark_rsp_valid_d = 1'b0;
    mark_fault_d     = 1'b0;
    timeout_d        = timeout_err;

    if (walk_req_valid) begin
      walk_pend_d = 1'b1;
      walk_addr_d = walk_req_addr;
    end
    if (mark_valid) begin
      mark_pend_d = 1'b1;
      mark_req_d  = '{accessed: mark_accessed, dirty: mark_dirty, addr: mark_addr};
    end

    case (state_q)
      IDLE: begin
        if (mark_pend_d) begin
          mark_pend_d = 1'b0;
          cur_acc_d   = mark_req_d.accessed;
          cur_dirty_d = mark_req_d.dirty;
          state_d     = MARK_RD;
          req_valid_d = 1'b1;
          req_addr_d  = align8(mark_req_d.addr[PA_WIDTH-1:0]);
          req_store_d = 1'b0;
          req_data_d  = '0;
        end else if (walk_pend_d) begin
          walk_pend_d = 1'b0;
          state_d     = WALK_RD;
          req_valid_d = 1'b1;
          req_addr_d  = align8(walk_addr_d);
          req_store_d = 1'b0;
          req_data_d  = '0;
        end
      end
      WALK_RD: begin
        if (mem_rsp_valid) begin
          walk_rsp_valid_d = 1'b1;
          walk_rsp_data_d  = mem_rsp_data;
          state_d          = IDLE;
        end else if (expired) begin
          timeout_d        = 1'b1;
          walk_rsp_valid_d = 1'b1;
          walk_rsp_data_d  = '0;
          state_d          = DONE;
        end
      end
      MARK_RD: begin
        if (mem_rsp_valid) begin
          pte_new_d = rsp_marked;
          state_d   = MARK_MOD;
          if (!mem_rsp_data[PTE_V]) begin
            mark_rsp_valid_d = 1'b1;
            mark_fault_d     = 1'b1;
            store_needed_d   = 1'b0;
          end else if (rsp_marked == mem_rsp_data) begin
            mark_rsp_valid_d = 1'b1;
            store_needed_d   = 1'b0;
          end else begin
            store_needed_d   = 1'b1;
          end
        end else if (expired) begin
          timeout_d        = 1'b1;
          mark_rsp_valid_d = 1'b1;
          mark_fault_d     = 1'b1;
          state_d          = DONE;
        end
      end
      MARK_MOD: begin
        if (store_needed_q) begin
          state_d     = MARK_WR;
          req_valid_d = 1'b1;
          req_store_d = 1'b1;
          req_data_d  = pte_new_q;
        end else begin
          state_d = DONE;
        end
      end
      MARK_WR: begin
        if (mem_rsp_valid) begin
          mark_rsp_valid_d = 1'b1;
          state_d          = DONE;
        end else if (expired) begin
          timeout_d        = 1'b1;
          mark_rsp_valid_d = 1'b1;
          mark_fault_d     = 1'b1;
          state_d          = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE) || walk_pend_d || mark_pend_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      walk_pend_q    <= 1'b0;
      walk_addr_q    <= '0;
      mark_pend_q    <= 1'b0;
      mark_req_q     <= '0;
      cur_acc_q      <= 1'b0;
      cur_dirty_q    <= 1'b0;
      pte_new_q      <= '0;
      store_needed_q <= 1'b0;
      mem_req_valid  <= 1'b0;
      mem_req_addr   <= '0;
      mem_req_store  <= 1'b0;
      mem_req_data   <= '0;
      walk_rsp_valid <= 1'b0;
      walk_rsp_data  <= '0;
      mark_rsp_valid <= 1'b0;
      mark_fault     <= 1'b0;
      timeout_err    <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state_q        <= state_d;
      walk_pend_q    <= walk_pend_d;
      walk_addr_q    <= walk_addr_d;
      mark_pend_q    <= mark_pend_d;
      mark_req_q     <= mark_req_d;
      cur_acc_q      <= cur_acc_d;
      cur_dirty_q    <= cur_dirty_d;
      pte_new_q      <= pte_new_d;
      store_needed_q <= store_needed_d;
      mem_req_valid  <= req_valid_d;
      mem_req_addr   <= req_addr_d;
      mem_req_store  <= req_store_d;
      mem_req_data   <= req_data_d;
      walk_rsp_valid <= walk_rsp_valid_d;
      walk_rsp_data  <= walk_rsp_data_d;
      mark_rsp_valid <= mark_rsp_valid_d;
      mark_fault     <= mark_fault_d;
      timeout_err    <= timeout_d;
      busy           <= busy_d;
    end
  end

  assign ctrl_state = state_q;

endmodule

// File: tb/tb_ptw_mem_ctrl.sv
// Directed bench for ptw_mem_ctrl: walk loads, A/D marks, arbitration,
// timeout and reset mid-transaction, with hand-computed expectations.
module tb_ptw_mem_ctrl;

  logic        clk;
  logic        reset;
  logic        walk_req_valid;
  logic [31:0] walk_req_addr;
  logic        walk_rsp_valid;
  logic [63:0] walk_rsp_data;
  logic        mark_valid;
  logic        mark_accessed;
  logic        mark_dirty;
  logic [63:0] mark_addr;
  logic        mark_rsp_valid;
  logic        mark_fault;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_store;
  logic [63:0] mem_req_data;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_data;
  logic        timeout_err;
  logic        busy;
  logic [2:0]  ctrl_state;

  int compared   = 0;
  int mismatched = 0;

  ptw_mem_ctrl #(.PA_WIDTH(32), .TIMEOUT(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .walk_req_valid (walk_req_valid),
    .walk_req_addr  (walk_req_addr),
    .walk_rsp_valid (walk_rsp_valid),
    .walk_rsp_data  (walk_rsp_data),
    .mark_valid     (mark_valid),
    .mark_accessed  (mark_accessed),
    .mark_dirty     (mark_dirty),
    .mark_addr      (mark_addr),
    .mark_rsp_valid (mark_rsp_valid),
    .mark_fault     (mark_fault),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_store  (mem_req_store),
    .mem_req_data   (mem_req_data),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .timeout_err    (timeout_err),
    .busy           (busy),
    .ctrl_state     (ctrl_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one cycle of inputs, then returns 1 time unit after the edge
  // that sampled them.
  task automatic applyStimulus(input logic wv, input logic [31:0] wa,
                               input logic mv, input logic ma, input logic md,
                               input logic [63:0] maddr,
                               input logic rv, input logic [63:0] rd);
    walk_req_valid = wv;
    walk_req_addr  = wa;
    mark_valid     = mv;
    mark_accessed  = ma;
    mark_dirty     = md;
    mark_addr      = maddr;
    mem_rsp_valid  = rv;
    mem_rsp_data   = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic stepIdle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    reset = 1'b1;
    stepIdle();
    stepIdle();
    checkOutput("rst_mem_req_valid", mem_req_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_state", ctrl_state, 0);
    checkOutput("rst_timeout", timeout_err, 0);
    checkOutput("rst_walk_rsp", walk_rsp_valid, 0);
    checkOutput("rst_mark_rsp", mark_rsp_valid, 0);
    reset = 1'b0;
    stepIdle();

    $display("[TB] walk load");
    applyStimulus(1'b1, 32'h8000_1008, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0);
    checkOutput("walk_req_valid", mem_req_valid, 1);
    checkOutput("walk_req_store", mem_req_store, 0);
    checkOutput("walk_req_addr", mem_req_addr, 32'h8000_1008);
    checkOutput("walk_req_data", mem_req_data, 0);
    checkOutput("walk_busy", busy, 1);
    checkOutput("walk_state", ctrl_state, 1);
    stepIdle();
    checkOutput("walk_req_pulse", mem_req_valid, 0);
    stepIdle();
    stepIdle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 64'h0000_0000_2000_0401);
    checkOutput("walk_rsp_valid", walk_rsp_valid, 1);
    checkOutput("walk_rsp_data", walk_rsp_data, 64'h0000_0000_2000_0401);
    checkOutput("walk_busy_after", busy, 0);
    stepIdle();
    checkOutput("walk_rsp_pulse", walk_rsp_valid, 0);

    $display("[TB] mark accessed");
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 64'h8000_2000, 1'b0, 64'h0);
    checkOutput("mA_rd_valid", mem_req_valid, 1);
    checkOutput("mA_rd_store", mem_req_store, 0);
    checkOutput("mA_rd_addr", mem_req_addr, 32'h8000_2000);
    checkOutput("mA_state_rd", ctrl_state, 2);
    stepIdle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 64'h1);
    checkOutput("mA_state_mod", ctrl_state, 3);
    checkOutput("mA_no_early_rsp", mark_rsp_valid, 0);
    stepIdle();
    checkOutput("mA_wr_valid", mem_req_valid, 1);
    checkOutput("mA_wr_store", mem_req_store, 1);
    checkOutput("mA_wr_addr", mem_req_addr, 32'h8000_2000);
    checkOutput("mA_wr_data", mem_req_data, 64'h41);
    checkOutput("mA_state_wr", ctrl_state, 4);
    stepIdle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 64'h0);
    checkOutput("mA_rsp_valid", mark_rsp_valid, 1);
    checkOutput("mA_fault", mark_fault, 0);
    checkOutput("mA_state_done", ctrl_state, 5);
    stepIdle();
    checkOutput("mA_state_idle", ctrl_state, 0);
    checkOutput("mA_busy_after", busy, 0);

    $display("[TB] mark dirty, bits already set");
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 64'h8000_3000, 1'b0, 64'h0);
    checkOutput("mD_rd_valid", mem_req_valid, 1);
    checkOutput("mD_rd_addr", mem_req_addr, 32'h8000_3000);
    stepIdle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 64'hC1);
    checkOutput("mD_rsp_valid", mark_rsp_valid, 1);
    checkOutput("mD_fault", mark_fault, 0);
    stepIdle();
    checkOutput("mD_no_store", mem_req_valid, 0);
    checkOutput("mD_state_done", ctrl_state, 5);

    $display("[TB] mark on invalid PTE");
    stepIdle();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 64'h8000_4000, 1'b0, 64'h0);
    checkOutput("mI_rd_valid", mem_req_valid, 1);
    stepIdle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 64'h0);
    checkOutput("mI_rsp_valid", mark_rsp_valid, 1);
    checkOutput("mI_fault", mark_fault, 1);
    stepIdle();
    checkOutput("mI_no_store", mem_req_valid, 0);
    stepIdle();

    $display("[TB] simultaneous walk and mark");
    applyStimulus(1'b1, 32'h8000_5000, 1'b1, 1'b1, 1'b0, 64'h8000_6000, 1'b0, 64'h0);
    checkOutput("sim_first_valid", mem_req_valid, 1);
    checkOutput("sim_first_addr", mem_req_addr, 32'h8000_6000);
    checkOutput("sim_first_store", mem_req_store, 0);
    stepIdle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 64'h1);
    checkOutput("sim_no_interleave", mem_req_valid, 0);
    stepIdle();
    checkOutput("sim_store_valid", mem_req_valid, 1);
    checkOutput("sim_store_store", mem_req_store, 1);
    checkOutput("sim_store_addr", mem_req_addr, 32'h8000_6000);
    checkOutput("sim_store_data", mem_req_data, 64'h41);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 64'h0);
    checkOutput("sim_mark_rsp", mark_rsp_valid, 1);
    checkOutput("sim_busy_pending", busy, 1);
    stepIdle();
    checkOutput("sim_bubble", mem_req_valid, 0);
    stepIdle();
    checkOutput("sim_walk_valid", mem_req_valid, 1);
    checkOutput("sim_walk_addr", mem_req_addr, 32'h8000_5000);
    checkOutput("sim_walk_store", mem_req_store, 0);
    stepIdle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 64'h1234);
    checkOutput("sim_walk_rsp", walk_rsp_valid, 1);
    checkOutput("sim_walk_data", walk_rsp_data, 64'h1234);
    checkOutput("sim_busy_after", busy, 0);

    $display("[TB] timeout");
    applyStimulus(1'b1, 32'h8000_7000, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0);
    checkOutput("to_req_valid", mem_req_valid, 1);
    for (int i = 0; i < 17; i++) stepIdle();
    checkOutput("to_not_yet", timeout_err, 0);
    checkOutput("to_no_rsp_yet", walk_rsp_valid, 0);
    stepIdle();
    checkOutput("to_err", timeout_err, 1);
    checkOutput("to_rsp_valid", walk_rsp_valid, 1);
    checkOutput("to_rsp_data", walk_rsp_data, 0);
    checkOutput("to_state_done", ctrl_state, 5);
    stepIdle();
    checkOutput("to_sticky", timeout_err, 1);
    checkOutput("to_state_idle", ctrl_state, 0);

    $display("[TB] reset mid-transaction");
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 64'h8000_8000, 1'b0, 64'h0);
    checkOutput("rm_req_valid", mem_req_valid, 1);
    for (int i = 0; i < 4; i++) stepIdle();
    reset = 1'b1;
    #1;
    checkOutput("rm_busy", busy, 0);
    checkOutput("rm_state", ctrl_state, 0);
    checkOutput("rm_timeout", timeout_err, 0);
    checkOutput("rm_req_addr", mem_req_addr, 0);
    checkOutput("rm_walk_data", walk_rsp_data, 0);
    stepIdle();
    reset = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 64'hFF);
    checkOutput("rm_late_mark_rsp", mark_rsp_valid, 0);
    checkOutput("rm_late_walk_rsp", walk_rsp_valid, 0);
    checkOutput("rm_late_state", ctrl_state, 0);
    checkOutput("rm_late_req", mem_req_valid, 0);
    stepIdle();
    checkOutput("rm_quiet_mark", mark_rsp_valid, 0);
    checkOutput("rm_quiet_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
